sample_window_buffer: RTL and testbench
=======================================

// Module: sample_window_buffer
// PURPOSE
//   Upstream stage of the six-tap averaging unit. Collects a serial stream of 8-bit samples into
//   a six-deep sliding window and presents all six taps in parallel on ad0..ad5.
//   Emits a valid/ready-qualified window for the averager to consume.
//   Supports optional decimation (one window per DECIM new samples) and a synchronous flush.
// PARAMETERS
//   DW     8  sample width in bits; also the width of each tap output
//   DECIM  1  new samples accepted per emitted window once full; legal range 1..15
// PORTS
//   clk        in   1   single system clock; all logic on rising edge
//   rst_n      in   1   synchronous, active-low reset
//   s_data     in   DW  incoming sample
//   s_valid    in   1   s_data valid
//   s_ready    out  1   buffer can accept a sample this cycle
//   flush      in   1   synchronous clear of window contents and counters
//   win_valid  out  1   ad0..ad5 hold a complete window
//   win_ready  in   1   downstream consumes the window this cycle
//   ad0..ad5   out  DW  taps; ad0 = oldest sample, ad5 = newest sample
//   overrun    out  1   sticky: sample offered while stalled (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     - ad0..ad5 = 0, win_valid = 0, fill_cnt = 0, dec_cnt = 0, overrun = 0, state = FILL.
//     - s_ready is forced to 0 while rst_n = 0.
//   Accept / pop:
//     - accept = s_valid & s_ready.
//     - pop = win_valid & win_ready.
//     - s_ready = rst_n & (~win_valid | win_ready); accept and pop in the same cycle is legal.
//   Shift on accept: ad0<=ad1, ad1<=ad2, ..., ad4<=ad5, ad5<=s_data. Taps are frozen otherwise.
//   FSM, 2 states:
//     - FILL: fill_cnt increments on each accept.
//       The accept that takes fill_cnt from 5 to 6 moves to FULL, sets win_valid, and clears dec_cnt.
//     - FULL: dec_cnt increments on each accept and wraps at DECIM-1.
//       The accept with dec_cnt == DECIM-1 sets win_valid and resets dec_cnt to 0.
//       With DECIM=1, every accept produces a window.
//   Latency: win_valid rises on the cycle after the completing accept.
//   win_valid:
//     - Stays high until pop.
//     - pop together with a window-completing accept keeps win_valid high (new window, no bubble).
//     - pop alone clears it.
//   Stall: while win_valid & ~win_ready, s_ready = 0 and ad0..ad5 stay stable (no shift).
//   flush: same-cycle effect as reset on taps, counters and win_valid; state returns to FILL.
//     - flush takes priority over a simultaneous accept; that sample is dropped.
//     - overrun is also cleared by flush.
//   Reset or flush mid-fill discards the partial window; 6 fresh samples are required before the next win_valid.
//   fill_cnt saturates at 6 (3 bits). dec_cnt is 4 bits; it never exceeds DECIM-1.
//   No arithmetic on samples; data passes through bit-exact.
// CONFIGURATION
//   OVERRUN_DETECT_EN defined:
//     - overrun is set on any cycle with s_valid & ~s_ready & rst_n.
//     - It is sticky until flush or reset.
//   OVERRUN_DETECT_EN undefined: overrun is tied to 0 and its register is not built. The port is always present.
// STRUCTURE
//   Package sample_win_pkg:
//     - NTAP = 6, FILL_W = 3, DEC_W = 4.
//     - State enum {ST_FILL, ST_FULL}.
//     - Default DW = 8.
//   Sub-module win_shift_reg: 6-entry DW-wide shift register with enable and sync clear, exposing all taps.
//   Top level holds the FSM, counters, handshake and overrun logic.
// TESTING
//   1. Reset, then feed 10,20,30,40,50,60 with win_ready=1 and DECIM=1.
//      -> win_valid one cycle after the 6th accept; ad0..ad5 = 10,20,30,40,50,60.
//   2. Continue with 70 -> ad0..ad5 = 20..70; win_valid stays high on back-to-back accept+pop (no bubble).
//   3. Hold win_ready=0 with s_valid=1 -> s_ready=0 and taps stable for 5 cycles.
//      With OVERRUN_DETECT_EN, overrun=1 and stays 1 after win_ready returns.
//   4. DECIM=3, full window, feed 3 more samples -> exactly one win_valid, after the 3rd; none after the 1st or 2nd.
//   5. flush asserted with an accept after 4 samples -> taps=0, win_valid=0, sample dropped.
//      The next window needs 6 new samples.
//   6. rst_n=0 for 1 cycle while win_valid=1 -> win_valid=0, s_ready=0 during reset, all taps 0 on the next cycle.

Source files
------------

// File: rtl/sample_window_buffer_pkg.sv
// Shared constants and FSM state type for the six-tap sample window buffer.
package sample_win_pkg;
  localparam int NTAP   = 6;
  localparam int FILL_W = 3;
  localparam int DEC_W  = 4;
  localparam int DW_DEF = 8;

  typedef enum logic {ST_FILL, ST_FULL} state_e;
endpackage

// File: rtl/sample_window_buffer_win_shift_reg.sv
// NTAP-deep, DW-wide shift register: taps[0] oldest, taps[NTAP-1] newest.
module win_shift_reg
  import sample_win_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic [DW-1:0]            din,
  output logic [NTAP-1:0][DW-1:0]  taps
);
  logic [NTAP-1:0][DW-1:0] nxt;

  assign nxt = {din, taps[NTAP-1:1]};

  always_ff @(posedge clk) begin
    if (clr)     taps <= '0;
    else if (en) taps <= nxt;
  end
endmodule

// File: rtl/sample_window_buffer.sv
// Sliding six-sample window with valid/ready output, decimation and flush.
// Optional OVERRUN_DETECT_EN builds the sticky overrun flag; otherwise it is tied to 0.
module sample_window_buffer
  import sample_win_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DECIM = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          flush,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [DW-1:0] ad0,
  output logic [DW-1:0] ad1,
  output logic [DW-1:0] ad2,
  output logic [DW-1:0] ad3,
  output logic [DW-1:0] ad4,
  output logic [DW-1:0] ad5,
  output logic          overrun
);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NTAP - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(NTAP);

  state_e              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [DEC_W-1:0]    dec_q, dec_d;
  logic                wv_q, wv_d;
  logic                accept, pop, win_done;
  logic [NTAP-1:0][DW-1:0] taps;

  assign s_ready   = rst_n & (~wv_q | win_ready);
  assign accept    = s_valid & s_ready;
  assign pop       = wv_q & win_ready;
  assign win_valid = wv_q;

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    dec_d    = dec_q;
    win_done = 1'b0;
    case (state_q)
      ST_FILL: if (accept) begin
        if (fill_q == FILL_LAST) begin
          state_d  = ST_FULL;
          fill_d   = FILL_MAX;
          dec_d    = '0;
          win_done = 1'b1;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      ST_FULL: if (accept) begin
        if (dec_q == DEC_LAST) begin
          dec_d    = '0;
          win_done = 1'b1;
        end else begin
          dec_d = dec_q + 1'b1;
        end
      end
      default: state_d = ST_FILL;
    endcase
    // A completing accept wins over a pop so back-to-back windows have no bubble
    if (win_done)  wv_d = 1'b1;
    else if (pop)  wv_d = 1'b0;
    else           wv_d = wv_q;
    if (flush) begin
      state_d = ST_FILL;
      fill_d  = '0;
      dec_d   = '0;
      wv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      dec_q   <= '0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      dec_q   <= dec_d;
      wv_q    <= wv_d;
    end
  end

  // flush drops a coincident sample: it clears instead of shifting
  win_shift_reg #(.DW(DW)) u_shift (
    .clk  (clk),
    .clr  (~rst_n | flush),
    .en   (accept & ~flush),
    .din  (s_data),
    .taps (taps)
  );

  assign ad0 = taps[0];
  assign ad1 = taps[1];
  assign ad2 = taps[2];
  assign ad3 = taps[3];
  assign ad4 = taps[4];
  assign ad5 = taps[5];

`ifdef OVERRUN_DETECT_EN
  logic ov_q;
  always_ff @(posedge clk) begin
    if (!rst_n || flush)        ov_q <= 1'b0;
    else if (s_valid & ~s_ready) ov_q <= 1'b1;
  end
  assign overrun = ov_q;
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_sample_window_buffer.sv
// Bench: table vectors + DECIM=3 sequence + random stimulus vs. a sample-count reference model.
module tb_sample_window_buffer;
`ifdef OVERRUN_DETECT_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, s_valid, flush, win_ready;
  logic [7:0] s_data;
  logic [1:0] rdy, wv, ov;
  logic [1:0][5:0][7:0] tp;

  sample_window_buffer #(.DW(8), .DECIM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[0]),
    .flush(flush), .win_valid(wv[0]), .win_ready(win_ready),
    .ad0(tp[0][0]), .ad1(tp[0][1]), .ad2(tp[0][2]), .ad3(tp[0][3]), .ad4(tp[0][4]), .ad5(tp[0][5]),
    .overrun(ov[0]));

  sample_window_buffer #(.DW(8), .DECIM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[1]),
    .flush(flush), .win_valid(wv[1]), .win_ready(win_ready),
    .ad0(tp[1][0]), .ad1(tp[1][1]), .ad2(tp[1][2]), .ad3(tp[1][3]), .ad4(tp[1][4]), .ad5(tp[1][5]),
    .overrun(ov[1]));

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: window emitted on the 6th sample since clear, then every DECIM-th after it
  int         m_n[2];
  logic       m_wv[2], m_ov[2];
  logic [7:0] m_tap[2][6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mdl_upd(input int k);
    int   dk;
    logic r, acc, pop, done;
    dk = (k == 0) ? 1 : 3;
    r  = rst_n & (!m_wv[k] | win_ready);
    if (!rst_n || flush) begin
      m_n[k] = 0; m_wv[k] = 1'b0; m_ov[k] = 1'b0;
      for (int j = 0; j < 6; j++) m_tap[k][j] = '0;
    end else begin
      acc  = s_valid & r;
      pop  = m_wv[k] & win_ready;
      done = 1'b0;
      if (OV_EN && s_valid && !r) m_ov[k] = 1'b1;
      if (acc) begin
        for (int j = 0; j < 5; j++) m_tap[k][j] = m_tap[k][j+1];
        m_tap[k][5] = s_data;
        m_n[k]++;
        done = (m_n[k] == 6) || (m_n[k] > 6 && ((m_n[k] - 6) % dk) == 0);
      end
      if (done)     m_wv[k] = 1'b1;
      else if (pop) m_wv[k] = 1'b0;
    end
  endtask

  task automatic mdl_chk(input int k);
    logic [5:0][7:0] et;
    logic            er;
    for (int j = 0; j < 6; j++) et[j] = m_tap[k][j];
    er = rst_n & (!m_wv[k] | win_ready);
    chk(k == 0 ? "model_d1" : "model_d3",
        64'({wv[k], rdy[k], ov[k], tp[k]}), 64'({m_wv[k], er, m_ov[k], et}));
  endtask

  task automatic step(input logic r, input logic sv, input logic [7:0] d,
                      input logic fl, input logic wr);
    rst_n = r; s_valid = sv; s_data = d; flush = fl; win_ready = wr;
    @(posedge clk);
    mdl_upd(0); mdl_upd(1);
    #1;
    mdl_chk(0); mdl_chk(1);
  endtask

  typedef struct {
    logic r, sv; logic [7:0] d; logic fl, wr;
    logic vld, rdy, ov; logic [7:0] a0, a5;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic sv, logic [7:0] d, logic fl, logic wr,
                              logic vld, logic rdy, logic ov, logic [7:0] a0, logic [7:0] a5);
    vec_t v;
    v.r = r; v.sv = sv; v.d = d; v.fl = fl; v.wr = wr;
    v.vld = vld; v.rdy = rdy; v.ov = ov; v.a0 = a0; v.a5 = a5;
    return v;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_wv[k] = 1'b0; m_ov[k] = 1'b0;
      for (int j = 0; j < 6; j++) m_tap[k][j] = '0;
    end
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0; win_ready = 1'b0;

    // Vectors for the DECIM=1 instance: r sv d fl wr | vld rdy ov ad0 ad5
    tbl.push_back(mk(0, 0, 8'd0, 0, 1, 0, 0, 0, 8'd0, 8'd0));
    for (int i = 1; i <= 6; i++)
      tbl.push_back(mk(1, 1, 8'(10*i), 0, 1, i == 6, 1, 0, i == 6 ? 8'd10 : 8'd0, 8'(10*i)));
    tbl.push_back(mk(1, 1, 8'd70, 0, 1, 1, 1, 0, 8'd20, 8'd70));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 1, 8'd99, 0, 0, 1, 0, OV_EN, 8'd20, 8'd70));
    tbl.push_back(mk(1, 0, 8'd0, 0, 1, 0, 1, OV_EN, 8'd20, 8'd70));
    tbl.push_back(mk(1, 0, 8'd0, 1, 1, 0, 1, 0, 8'd0, 8'd0));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(1, 1, 8'(i), 0, 1, 0, 1, 0, 8'd0, 8'(i)));
    tbl.push_back(mk(1, 1, 8'd5, 1, 1, 0, 1, 0, 8'd0, 8'd0));
    for (int i = 1; i <= 6; i++)
      tbl.push_back(mk(1, 1, 8'(10+i), 0, 1, i == 6, 1, 0, i == 6 ? 8'd11 : 8'd0, 8'(10+i)));
    tbl.push_back(mk(0, 1, 8'd77, 0, 0, 0, 0, 0, 8'd0, 8'd0));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0, 0, 1, 0, 8'd0, 8'd0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].sv, tbl[i].d, tbl[i].fl, tbl[i].wr);
      chk($sformatf("tbl%0d", i),
          64'({wv[0], rdy[0], ov[0], tp[0][0], tp[0][5]}),
          64'({tbl[i].vld, tbl[i].rdy, tbl[i].ov, tbl[i].a0, tbl[i].a5}));
    end

    // DECIM=3: first window after 6 samples, next only after 3 more
    step(0, 0, 8'd0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 8'(i+1), 0, 1);
      chk($sformatf("d3_vld%0d", i), 64'(wv[1]), 64'(i == 5 || i == 8));
    end
    chk("d3_taps", 64'({tp[1][0], tp[1][5]}), 64'({8'd4, 8'd9}));

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) != 0, $urandom_range(0, 9) < 7, 8'($urandom),
           $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
